// File: rtl/kalman_gain_div.sv
// Kalman gain divider: K = floor(num * 2^FRAC_W / denom) in Q0.FRAC_W, restoring
// division one quotient bit per cycle, with saturation and divide-by-zero flags.
module kalman_gain_div #(
   parameter int DATA_W = 64,
   parameter int FRAC_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] S_AXIS_IN_num,
   input  logic [DATA_W-1:0] S_AXIS_IN_denom,
   input  logic              S_AXIS_IN_tvalid,
   output logic              S_AXIS_IN_tready,
   output logic [FRAC_W-1:0] M_AXIS_OUT_tdata,
   output logic              M_AXIS_OUT_tvalid,
   input  logic              M_AXIS_OUT_tready,
   output logic              sat,
   output logic              div_zero,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int              CNT_W    = $clog2(FRAC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAC_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t              state_r;
   state_t              state_s;
   logic                accept_s;
   logic                deliver_s;
   logic                early_s;
   logic [DATA_W:0]     rem_r;
   logic [DATA_W:0]     rem_sh_s;
   logic [DATA_W:0]     rem_nx_s;
   logic                q_bit_s;
   logic [DATA_W-1:0]   den_r;
   logic [FRAC_W-1:0]   quo_r;
   logic [FRAC_W-1:0]   quo_nx_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [FRAC_W-1:0]   tdata_r;
   logic                sat_r;
   logic                dz_r;
   logic                tready_r;
   logic                tvalid_r;
   logic                busy_r;

   assign accept_s  = S_AXIS_IN_tvalid & tready_r;
   assign deliver_s = tvalid_r & M_AXIS_OUT_tready;
   // Zero denominator or a ratio >= 1 resolves immediately without iterating.
   assign early_s   = (S_AXIS_IN_denom == {DATA_W{1'b0}}) ||
                      (S_AXIS_IN_num >= S_AXIS_IN_denom);

   // One restoring-division step; remainder stays < denom so DATA_W+1 bits never overflow.
   always_comb begin
      rem_sh_s = {rem_r[DATA_W-1:0], 1'b0};
      rem_nx_s = rem_sh_s;
      q_bit_s  = 1'b0;
      if (rem_sh_s >= {1'b0, den_r}) begin
         rem_nx_s = rem_sh_s - {1'b0, den_r};
         q_bit_s  = 1'b1;
      end else begin
         rem_nx_s = rem_sh_s;
         q_bit_s  = 1'b0;
      end
      quo_nx_s = {quo_r[FRAC_W-2:0], q_bit_s};
   end

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (early_s) begin
                  state_s = DONE;
               end else begin
                  state_s = CALC;
               end
            end else begin
               state_s = IDLE;
            end
         end
         CALC: begin
            if (cnt_r == CNT_LAST) begin
               state_s = DONE;
            end else begin
               state_s = CALC;
            end
         end
         DONE: begin
            if (deliver_s) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Handshake/status outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         tready_r <= 1'b1;
         tvalid_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         tready_r <= (state_s == IDLE);
         tvalid_r <= (state_s == DONE);
         busy_r   <= (state_s != IDLE);
      end
   end

   // Operand capture, iteration and result/flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rem_r   <= {(DATA_W+1){1'b0}};
         den_r   <= {DATA_W{1'b0}};
         quo_r   <= {FRAC_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         tdata_r <= {FRAC_W{1'b0}};
         sat_r   <= 1'b0;
         dz_r    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  rem_r <= {1'b0, S_AXIS_IN_num};
                  den_r <= S_AXIS_IN_denom;
                  quo_r <= {FRAC_W{1'b0}};
                  cnt_r <= {CNT_W{1'b0}};
                  if (S_AXIS_IN_denom == {DATA_W{1'b0}}) begin
                     tdata_r <= {FRAC_W{1'b1}};
                     dz_r    <= 1'b1;
                     sat_r   <= 1'b0;
                  end else if (S_AXIS_IN_num >= S_AXIS_IN_denom) begin
                     tdata_r <= {FRAC_W{1'b1}};
                     dz_r    <= 1'b0;
                     sat_r   <= 1'b1;
                  end
               end
            end
            CALC: begin
               rem_r <= rem_nx_s;
               quo_r <= quo_nx_s;
               cnt_r <= cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  tdata_r <= quo_nx_s;
               end
            end
            DONE: begin
               if (deliver_s) begin
                  sat_r <= 1'b0;
                  dz_r  <= 1'b0;
               end
            end
            default: begin
               sat_r <= 1'b0;
               dz_r  <= 1'b0;
            end
         endcase
      end
   end

   assign S_AXIS_IN_tready  = tready_r;
   assign M_AXIS_OUT_tvalid = tvalid_r;
   assign M_AXIS_OUT_tdata  = tdata_r;
   assign sat               = sat_r;
   assign div_zero          = dz_r;
   assign busy              = busy_r;

endmodule

// File: tb/tb_kalman_gain_div.sv
// Directed and reference-model checks for kalman_gain_div (DATA_W=64, FRAC_W=32).
module tb_kalman_gain_div;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] num = 64'd0;
   logic [63:0] den = 64'd0;
   logic        in_tvalid = 1'b0;
   logic        in_tready;
   logic [31:0] out_tdata;
   logic        out_tvalid;
   logic        out_tready = 1'b1;
   logic        sat;
   logic        div_zero;
   logic        busy;

   int total = 0;
   int bad   = 0;

   kalman_gain_div #(.DATA_W(64), .FRAC_W(32)) dut (
      .clk               (clk),
      .rst               (rst),
      .S_AXIS_IN_num     (num),
      .S_AXIS_IN_denom   (den),
      .S_AXIS_IN_tvalid  (in_tvalid),
      .S_AXIS_IN_tready  (in_tready),
      .M_AXIS_OUT_tdata  (out_tdata),
      .M_AXIS_OUT_tvalid (out_tvalid),
      .M_AXIS_OUT_tready (out_tready),
      .sat               (sat),
      .div_zero          (div_zero),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for tready, present one operand pair for exactly one edge.
   task automatic send(input logic [63:0] n, input logic [63:0] d);
      int g;
      g = 0;
      while (!in_tready && g < 200) begin
         tick();
         g++;
      end
      chk("send_rdy", in_tready, 1);
      num = n;
      den = d;
      in_tvalid = 1'b1;
      tick();
      in_tvalid = 1'b0;
   endtask

   // Latency counted in edges, the acceptance edge being edge 1.
   task automatic wait_out(output int lat);
      lat = 1;
      while (!out_tvalid && lat < 100) begin
         tick();
         lat++;
      end
      chk("out_vld", out_tvalid, 1);
   endtask

   initial begin
      int          lat;
      logic [31:0] held;
      logic [63:0] r;
      logic [127:0] prod;
      logic [63:0] expq;

      // reset with a pending operand: reset must win
      num = 64'd1; den = 64'd2; in_tvalid = 1'b1;
      tick(); tick();
      in_tvalid = 1'b0;
      chk("rst_tvalid", out_tvalid, 0);
      chk("rst_tdata", out_tdata, 0);
      chk("rst_sat", sat, 0);
      chk("rst_dz", div_zero, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;
      tick();
      chk("rst_rdy", in_tready, 1);
      chk("rst_noacc", busy, 0);

      // 1/2
      send(64'd1, 64'd2);
      chk("half_busy", busy, 1);
      chk("half_rdy_lo", in_tready, 0);
      wait_out(lat);
      chk("half_lat", lat, 33);
      chk("half_q", out_tdata, 32'h8000_0000);
      chk("half_sat", sat, 0);
      chk("half_dz", div_zero, 0);
      chk("half_rdy_done", in_tready, 0);
      tick();
      chk("half_ret_vld", out_tvalid, 0);
      chk("half_ret_rdy", in_tready, 1);

      // back-to-back 3/4 then 1/3
      send(64'd3, 64'd4);
      wait_out(lat);
      chk("b2b0_q", out_tdata, 32'hC000_0000);
      chk("b2b_rdy_lo", in_tready, 0);
      send(64'd1, 64'd3);
      wait_out(lat);
      chk("b2b1_q", out_tdata, 32'h5555_5555);
      tick();

      // saturation and divide by zero
      send(64'd7, 64'd7);
      wait_out(lat);
      chk("sat_lat", lat, 1);
      chk("sat_q", out_tdata, 32'hFFFF_FFFF);
      chk("sat_flag", sat, 1);
      chk("sat_dz", div_zero, 0);
      tick();
      chk("sat_clr", sat, 0);
      send(64'd5, 64'd0);
      wait_out(lat);
      chk("dz_lat", lat, 1);
      chk("dz_q", out_tdata, 32'hFFFF_FFFF);
      chk("dz_flag", div_zero, 1);
      chk("dz_sat", sat, 0);
      tick();
      chk("dz_clr", div_zero, 0);

      // backpressure
      out_tready = 1'b0;
      send(64'd1, 64'd4);
      wait_out(lat);
      held = out_tdata;
      chk("bp_q", held, 32'h4000_0000);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_vld", out_tvalid, 1);
         chk("bp_hold", out_tdata, 32'h4000_0000);
         chk("bp_busy", busy, 1);
         chk("bp_rdy", in_tready, 0);
      end
      out_tready = 1'b1;
      tick();
      chk("bp_ret_vld", out_tvalid, 0);
      chk("bp_ret_rdy", in_tready, 1);
      chk("bp_ret_busy", busy, 0);
      chk("bp_keep_q", out_tdata, 32'h4000_0000);

      // reset in the middle of a division
      send(64'd1, 64'd2);
      repeat (10) tick();
      chk("ab_busy", busy, 1);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ab_vld", out_tvalid, 0);
         chk("ab_busy0", busy, 0);
         chk("ab_q", out_tdata, 0);
         chk("ab_flags", {sat, div_zero}, 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("ab_quiet", out_tvalid, 0);
      end
      chk("ab_rdy", in_tready, 1);
      send(64'd1, 64'd2);
      wait_out(lat);
      chk("ab_lat", lat, 33);
      chk("ab_q2", out_tdata, 32'h8000_0000);
      tick();

      // random num < denom against a wide-integer reference
      for (int i = 0; i < 1000; i++) begin
         r = {$urandom(), $urandom()};
         if (i % 4 == 0) r = r >> $urandom_range(63, 0);
         if (r == 64'd0) r = 64'd1;
         expq = {$urandom(), $urandom()};
         expq = expq % r;
         prod = {32'd0, expq, 32'd0};
         send(expq, r);
         prod = prod / {64'd0, r};
         wait_out(lat);
         chk("rnd_q", out_tdata, prod[63:0]);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
